// File: rtl/lot_pkg.sv
// Shared constants for the lottery checker: FSM state codes, prize codes and
// the largest legal BCD digit.
package lot_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_DRAW = 3'd1;
  localparam logic [2:0] ST_ENTRY     = 3'd2;
  localparam logic [2:0] ST_CHECK     = 3'd3;
  localparam logic [2:0] ST_RESULT    = 3'd4;

  localparam logic [1:0] PRIZE_NONE   = 2'd0;
  localparam logic [1:0] PRIZE_TOP    = 2'd1;
  localparam logic [1:0] PRIZE_SECOND = 2'd2;

  localparam int unsigned BCD_MAX = 9;

endpackage

// File: rtl/lot_checker_param_if.sv
// Front-end / display side bundle of the lottery checker; clk and reset stay
// outside as plain ports.
interface lot_checker_param_if #(
  parameter int unsigned N_DIGITS  = 5,
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned CNT_W     = 4
);
  localparam int unsigned CW = $clog2(N_DIGITS + 1);
  localparam int unsigned PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

  logic [DIGIT_W-1:0]          num;
  logic                        insere;
  logic                        draw_load;
  logic                        fim;
  logic                        fim_jogo;
  logic [2:0]                  state;
  logic [CW-1:0]               dig_cnt;
  logic [PW-1:0]               player;
  logic [N_DIGITS*DIGIT_W-1:0] ticket;
  logic [1:0]                  prize;
  logic                        prize_valid;
  logic                        err;
  logic                        draw_valid;
  logic [N_PLAYERS*CNT_W-1:0]  wins;

  modport master (
    output num, insere, draw_load, fim, fim_jogo,
    input  state, dig_cnt, player, ticket, prize, prize_valid, err,
           draw_valid, wins
  );

  modport slave (
    input  num, insere, draw_load, fim, fim_jogo,
    output state, dig_cnt, player, ticket, prize, prize_valid, err,
           draw_valid, wins
  );

endinterface

// File: rtl/lot_grade.sv
// Combinational ticket grader: longest run of positional matches over all
// but the last digit, the last-digit match, and the resulting prize code.
module lot_grade
  import lot_pkg::*;
#(
  parameter int unsigned N_DIGITS = 5,
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned RUN_HI   = 3,
  parameter int unsigned RUN_LO   = 2,
  localparam int unsigned TW      = N_DIGITS * DIGIT_W,
  localparam int unsigned CW      = $clog2(N_DIGITS + 1)
) (
  input  logic [TW-1:0] ticket,
  input  logic [TW-1:0] draw,
  output logic [CW-1:0] run,
  output logic          last,
  output logic [1:0]    prize
);

  int unsigned cur;
  int unsigned best;

  // Position 0 is the first digit entered, which sits in the MS slot.
  always_comb begin
    cur  = 0;
    best = 0;
    for (int unsigned i = 0; i < N_DIGITS - 1; i++) begin
      if (ticket[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W] ==
          draw[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W]) begin
        cur = cur + 1;
      end else begin
        cur = 0;
      end
      if (cur > best) best = cur;
    end
    run  = CW'(best);
    last = (ticket[DIGIT_W-1:0] == draw[DIGIT_W-1:0]);
    if (best >= RUN_HI) begin
      prize = PRIZE_TOP;
    end else if (best >= RUN_LO && last) begin
      prize = PRIZE_SECOND;
    end else begin
      prize = PRIZE_NONE;
    end
  end

endmodule

// File: rtl/lot_checker_param.sv
// Parametrised lottery checker: loads a draw, captures BCD tickets, grades
// them and keeps a saturating win counter per rotating player.
module lot_checker_param
  import lot_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 5,
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned RUN_HI    = 3,
  parameter int unsigned RUN_LO    = 2,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  lot_checker_param_if.slave bus
);

  localparam int unsigned TW = N_DIGITS * DIGIT_W;
  localparam int unsigned CW = $clog2(N_DIGITS + 1);
  localparam int unsigned PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [CW-1:0]      FULL      = CW'(N_DIGITS);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(BCD_MAX);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    dig_cnt_q, dig_cnt_d;
  logic [PW-1:0]    player_q, player_d;
  logic [TW-1:0]    ticket_q, ticket_d;
  logic [TW-1:0]    draw_q, draw_d;
  logic [1:0]       prize_q, prize_d;
  logic             prize_valid_q, prize_valid_d;
  logic             err_q, err_d;
  logic             draw_valid_q, draw_valid_d;
  logic [CNT_W-1:0] wins_q [N_PLAYERS];
  logic [CNT_W-1:0] wins_d [N_PLAYERS];

  logic [CW-1:0] grade_run;
  logic          grade_last;
  logic [1:0]    grade_prize;
  logic          grade_win;

  logic          digit_ok;
  logic          cap_ok;
  logic [TW-1:0] fresh;
  logic [TW-1:0] ticket_sh;
  logic [TW-1:0] draw_sh;
  logic [N_PLAYERS*CNT_W-1:0] wins_flat;

  lot_grade #(
    .N_DIGITS (N_DIGITS),
    .DIGIT_W  (DIGIT_W),
    .RUN_HI   (RUN_HI),
    .RUN_LO   (RUN_LO)
  ) u_grade (
    .ticket (ticket_q),
    .draw   (draw_q),
    .run    (grade_run),
    .last   (grade_last),
    .prize  (grade_prize)
  );

  assign grade_win = (int'(grade_run) >= int'(RUN_HI)) ||
                     ((int'(grade_run) >= int'(RUN_LO)) && grade_last);

  assign digit_ok  = (bus.num <= DIGIT_MAX);
  assign cap_ok    = digit_ok && (dig_cnt_q < FULL);
  assign fresh     = {{(TW-DIGIT_W){1'b0}}, bus.num};
  assign ticket_sh = {ticket_q[TW-DIGIT_W-1:0], bus.num};
  assign draw_sh   = {draw_q[TW-DIGIT_W-1:0], bus.num};

  always_comb begin
    state_d       = state_q;
    dig_cnt_d     = dig_cnt_q;
    player_d      = player_q;
    ticket_d      = ticket_q;
    draw_d        = draw_q;
    prize_d       = prize_q;
    prize_valid_d = 1'b0;
    err_d         = err_q;
    draw_valid_d  = draw_valid_q;
    wins_d        = wins_q;

    case (state_q)
      ST_IDLE: begin
        // The first digit of a draw or ticket is taken on the same edge that
        // leaves IDLE, so the register starts from a cleared value.
        if (bus.draw_load) begin
          state_d      = ST_LOAD_DRAW;
          draw_valid_d = 1'b0;
          err_d        = !digit_ok;
          draw_d       = digit_ok ? fresh : '0;
          dig_cnt_d    = digit_ok ? CW'(1) : '0;
        end else if (bus.insere) begin
          if (draw_valid_q) begin
            state_d   = ST_ENTRY;
            err_d     = !digit_ok;
            ticket_d  = digit_ok ? fresh : '0;
            dig_cnt_d = digit_ok ? CW'(1) : '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD_DRAW: begin
        if (bus.fim) begin
          state_d   = ST_IDLE;
          dig_cnt_d = '0;
          if (dig_cnt_q == FULL) begin
            draw_valid_d = 1'b1;
          end else begin
            draw_valid_d = 1'b0;
            err_d        = 1'b1;
          end
        end else if (bus.draw_load) begin
          if (cap_ok) begin
            draw_d    = draw_sh;
            dig_cnt_d = dig_cnt_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_ENTRY: begin
        if (bus.fim) begin
          if (dig_cnt_q == FULL) begin
            state_d = ST_CHECK;
          end else begin
            state_d   = ST_IDLE;
            err_d     = 1'b1;
            ticket_d  = '0;
            dig_cnt_d = '0;
          end
        end else if (bus.insere) begin
          if (cap_ok) begin
            ticket_d  = ticket_sh;
            dig_cnt_d = dig_cnt_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        state_d       = ST_RESULT;
        prize_d       = grade_prize;
        prize_valid_d = 1'b1;
        if (grade_win && (wins_q[player_q] != '1)) begin
          wins_d[player_q] = wins_q[player_q] + CNT_W'(1);
        end
      end

      ST_RESULT: begin
        if (bus.fim_jogo) begin
          state_d   = ST_IDLE;
          dig_cnt_d = '0;
          if (player_q == PW'(N_PLAYERS - 1)) begin
            player_d = '0;
          end else begin
            player_d = player_q + PW'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dig_cnt_q     <= '0;
      player_q      <= '0;
      ticket_q      <= '0;
      draw_q        <= '0;
      prize_q       <= PRIZE_NONE;
      prize_valid_q <= 1'b0;
      err_q         <= 1'b0;
      draw_valid_q  <= 1'b0;
      wins_q        <= '{default: '0};
    end else begin
      state_q       <= state_d;
      dig_cnt_q     <= dig_cnt_d;
      player_q      <= player_d;
      ticket_q      <= ticket_d;
      draw_q        <= draw_d;
      prize_q       <= prize_d;
      prize_valid_q <= prize_valid_d;
      err_q         <= err_d;
      draw_valid_q  <= draw_valid_d;
      wins_q        <= wins_d;
    end
  end

  always_comb begin
    wins_flat = '0;
    for (int unsigned p = 0; p < N_PLAYERS; p++) begin
      wins_flat[p*CNT_W +: CNT_W] = wins_q[p];
    end
  end

  assign bus.state       = state_q;
  assign bus.dig_cnt     = dig_cnt_q;
  assign bus.player      = player_q;
  assign bus.ticket      = ticket_q;
  assign bus.prize       = prize_q;
  assign bus.prize_valid = prize_valid_q;
  assign bus.err         = err_q;
  assign bus.draw_valid  = draw_valid_q;
  assign bus.wins        = wins_flat;

endmodule

// File: doc/lot_checker_param.md
Name: lot_checker_param

Overview:
Parametrised successor of the 5-digit lottery checker. Holds a loadable drawn number and accepts tickets of N_DIGITS BCD digits, one digit per clock while `insere` is high. On `fim` it grades the ticket against the draw using a run-of-matches rule, then holds the result until `fim_jogo`. Tickets rotate through N_PLAYERS players, and the block keeps a saturating win counter per player. It sits between the switch/button front end and the hex/LED display logic inside Top.

Parameters:
N_DIGITS, 5, digits per ticket and per draw (≥3)
DIGIT_W, 4, bits per digit (BCD)
N_PLAYERS, 2, players rotating ticket ownership (≥1)
RUN_HI, 3, consecutive matches required for prize 1
RUN_LO, 2, consecutive matches required for prize 2 (needs last-digit match too)
CNT_W, 4, width of each per-player win counter

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
num  in  DIGIT_W  digit input (draw or ticket)
insere  in  1  level: capture one ticket digit per cycle
draw_load  in  1  level: capture one draw digit per cycle
fim  in  1  end of ticket entry / end of draw load
fim_jogo  in  1  acknowledge result, return to IDLE
state  out  3  FSM state code
dig_cnt  out  $clog2(N_DIGITS+1)  digits captured so far
player  out  $clog2(N_PLAYERS) (min 1)  owner of current ticket
ticket  out  N_DIGITS*DIGIT_W  captured ticket, first digit in the MS slot
prize  out  2  0 none, 1 top prize, 2 second prize
prize_valid  out  1  one-cycle pulse when the prize is updated
err  out  1  sticky error, cleared on next IDLE exit
draw_valid  out  1  a full draw is stored
wins  out  N_PLAYERS*CNT_W  per-player win counters, player 0 in the LS slot

Behaviour:
- Reset: state=IDLE(0), dig_cnt=0, player=0, ticket=0, prize=0, prize_valid=0, err=0, draw_valid=0, wins=0, draw register=0.
- States: IDLE=0, LOAD_DRAW=1, ENTRY=2, CHECK=3, RESULT=4.
- Digit capture:
  - A digit is captured by shifting it in at the LS slot of the ticket or draw register. Entry order therefore equals the significance order.
  - Only valid digits are captured. A valid digit is ≤9 and arrives while dig_cnt<N_DIGITS.
  - A digit >9 is not captured and sets err.
  - A digit arriving while dig_cnt==N_DIGITS is not captured and sets err.
- IDLE:
  - draw_load=1: go to LOAD_DRAW and capture num in the same cycle; clear err; dig_cnt=1.
  - Else insere=1 with draw_valid=1: go to ENTRY, capture num, clear err and ticket first.
  - insere=1 with draw_valid=0: set err, stay in IDLE.
  - draw_load has priority over insere.
- LOAD_DRAW:
  - Capture a digit each cycle draw_load=1.
  - fim=1: if dig_cnt==N_DIGITS, set draw_valid=1; else err=1 and draw_valid=0.
  - On fim, return to IDLE and set dig_cnt=0.
  - While in LOAD_DRAW, draw_valid=0.
- ENTRY:
  - Capture a digit each cycle insere=1; insere=0 simply waits.
  - fim=1 with dig_cnt==N_DIGITS: go to CHECK.
  - fim=1 with dig_cnt<N_DIGITS: set err, discard the ticket, go to IDLE. player does not advance.
  - fim and insere in the same cycle: fim wins and that digit is dropped.
- CHECK (exactly one cycle):
  - run = longest streak of positionally equal digits over positions 0..N_DIGITS-2.
  - last = (position N_DIGITS-1 equal).
  - prize = 1 if run≥RUN_HI; else 2 if run≥RUN_LO and last; else 0.
  - If prize≠0, increment wins[player], saturating at 2^CNT_W-1.
  - Go to RESULT. prize and prize_valid are registered, so prize_valid is high in the first RESULT cycle only.
  - Latency from the fim edge to prize_valid is 2 cycles.
- RESULT:
  - Hold prize and ticket.
  - fim_jogo=1: go to IDLE, player=(player+1) mod N_PLAYERS, dig_cnt=0. prize is held until the next CHECK.
  - insere, draw_load and fim are ignored.
- dig_cnt saturates at N_DIGITS.
- reset in any state (mid-entry, mid-draw) forces the full reset values, including draw_valid=0 and wins=0.
- fim_jogo outside RESULT is ignored.

Decomposition:
- Shared package lot_pkg holds:
  - state enum codes (IDLE..RESULT);
  - prize codes PRIZE_NONE=0, PRIZE_TOP=1, PRIZE_SECOND=2;
  - BCD_MAX=9.
- One sub-module, lot_grade: purely combinational. Takes ticket and draw vectors plus the RUN_HI/RUN_LO parameters and returns run, last and prize. It is instantiated once and registered in CHECK.

Test Plan:
- Load draw 4,7,0,1,9 via draw_load then fim → draw_valid=1, err=0. Then ticket 4,7,0,1,0 + fim → 2 cycles later prize_valid pulse, prize=1 (run 4), wins[0]=1.
- fim_jogo, then ticket 6,7,0,3,9 → prize=2 (run 2 + last), player=1, wins[1]=1. Then ticket 4,7,0,2,9 → prize=1 (run 3), player=0, wins[0]=2.
- Tickets 2,3,1,1,9 and 4,9,2,1,9 → prize=0 for both (runs of 1), wins unchanged.
- Ticket of 3 digits then fim → err=1, state=IDLE, player unchanged. A digit 12 mid-entry → err=1 and dig_cnt unchanged. A 6th digit → ignored, err=1.
- insere before any draw is loaded → err=1, stays in IDLE. reset asserted mid-ENTRY after 2 digits → all outputs return to reset values next cycle.
- CNT_W=2, 4 winning tickets for one player (N_PLAYERS=1) → wins saturates at 3.
